// File: rtl/expr_regr_pkg.sv
// Shared types and defaults for the expression-block regression harness.
// Used by the result MISR, the operand generator and the expression wrapper.
package expr_regr_pkg;

    localparam int RESULT_W  = 90;
    localparam int VEC_CNT_W = 16;

    typedef logic [RESULT_W-1:0] result_t;

    // Feedback polynomial x^90 + x^89 + x^88 + x^87 + 1, bits {89,88,87,0}
    localparam result_t DEF_TAPS = result_t'(1) | (result_t'(7) << 87);
    localparam result_t DEF_SEED = '0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/expr_result_misr_if.sv
// Result-in and signature-out handshakes of the result MISR.
// master is the harness side, slave is the MISR.
interface expr_result_misr_if
    import expr_regr_pkg::*;
#(
    parameter int WIDTH = RESULT_W,
    parameter int CNT_W = VEC_CNT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sig_valid;
    logic             sig_ready;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] vec_count;

    modport master (
        output in_valid,
        output in_data,
        output sig_ready,
        input  in_ready,
        input  sig_valid,
        input  signature,
        input  vec_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  sig_ready,
        output in_ready,
        output sig_valid,
        output signature,
        output vec_count
    );

endinterface

// File: rtl/misr_step.sv
// One MISR step: shift left, fold the MSB back through the taps,
// then mix in the new result word. Pure XOR, no carries.
module misr_step
    import expr_regr_pkg::*;
#(
    parameter int               WIDTH = RESULT_W,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] fold;

    assign fold = sig[WIDTH-1] ? TAPS : '0;
    assign next = {sig[WIDTH-2:0], 1'b0} ^ fold ^ data;

endmodule

// File: rtl/expr_result_misr.sv
// Compacts a programmed number of expression results into one signature.
// Handshake flags decode from the state register only.
module expr_result_misr
    import expr_regr_pkg::*;
#(
    parameter int               WIDTH = RESULT_W,
    parameter int               CNT_W = VEC_CNT_W,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vectors,
    output logic               busy,
    expr_result_misr_if.slave  bus
);

    state_e           state;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] target;
    logic             accept;

    misr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .sig  (sig_q),
        .data (bus.in_data),
        .next (sig_next)
    );

    assign bus.in_ready  = (state == RUN);
    assign bus.sig_valid = (state == DONE);
    assign busy          = (state != IDLE);
    assign bus.signature = sig_q;
    assign bus.vec_count = cnt_q;

    assign accept   = bus.in_valid && (state == RUN);
    assign cnt_next = cnt_q + CNT_W'(1);

    // Run control, signature accumulation and vector counting
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sig_q  <= SEED;
            cnt_q  <= '0;
            target <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sig_q  <= SEED;
                        cnt_q  <= '0;
                        target <= num_vectors;
                        state  <= (num_vectors == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sig_q <= sig_next;
                        cnt_q <= cnt_next;
                        if (cnt_next == target) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.sig_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/expr_result_misr.md
# expr_result_misr

Downstream capture stage for the expression-block regression harness. It consumes the 90-bit `y` result bus of a generated expression block, one vector per accepted beat, and compacts a programmed number of results into a 90-bit multiple-input signature register (MISR). It then presents the final signature and vector count for comparison against a golden value. One signature replaces a per-vector compare, so long random runs need only a single check.

## Interface
- `WIDTH`, 90: result/signature width (matches the 90-bit `y` concatenation)
- `CNT_W`, 16: vector counter width
- `TAPS`, bits {89,88,87,0} set: MISR feedback polynomial mask, WIDTH bits
- `SEED`, 0: signature value loaded on reset and on start

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `num_vectors`  in  CNT_W  vectors to compact; sampled with `start`
- `in_valid`  in  1  `in_data` holds a result
- `in_ready`  out  1  block accepts a result this cycle
- `in_data`  in  WIDTH  expression result `y`
- `sig_valid`  out  1  signature available
- `sig_ready`  in  1  consumer takes the signature
- `signature`  out  WIDTH  current MISR value
- `vec_count`  out  CNT_W  results accepted this run
- `busy`  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. State, `signature`, `vec_count` and the latched `num_vectors` are registers.
- IDLE:
  - `start`=1 and `num_vectors`≠0: go to RUN; load `signature`←SEED, `vec_count`←0, latch `num_vectors`.
  - `start`=1 and `num_vectors`=0: go to DONE with `signature`=SEED and `vec_count`=0.
- RUN:
  - `in_ready`=1. An accept is a cycle with `in_valid`&&`in_ready`.
  - On accept: fb=`signature[WIDTH-1]`; `signature` ← ({`signature[WIDTH-2:0]`,0} ^ (fb ? TAPS : 0)) ^ `in_data`; `vec_count`++.
  - On the accept that makes `vec_count` equal the latched count, go to DONE.
  - With no accept, everything holds.
- DONE:
  - `sig_valid`=1 and `in_ready`=0; `signature` and `vec_count` hold.
  - `sig_valid`&&`sig_ready` returns to IDLE. `signature` and `vec_count` keep their values in IDLE until the next `start` or reset.
- `start` is ignored outside IDLE. Changes to `num_vectors` after latch have no effect.
- Arithmetic: the MISR update is pure XOR/shift at WIDTH bits with no carries. `vec_count` cannot wrap, because the run ends at `num_vectors` ≤ 2^CNT_W−1.
- `in_data` is sampled only on accept. Its value when `in_ready`=0 is don't-care.

## Timing
- Reset values: state IDLE, `in_ready`=0, `sig_valid`=0, `busy`=0, `signature`=SEED, `vec_count`=0.
- Reset mid-run or in DONE aborts the run. Outputs reach their reset values the cycle after `reset` is sampled high. A pending signature is discarded.
- `in_ready`, `sig_valid` and `busy` decode only from the state register. They have no combinational path from `in_valid` or `sig_ready`.
- Latency:
  - `start` to `in_ready`=1: one cycle.
  - Last accept to `sig_valid`=1: one cycle.
  - `signature` reflects an accepted vector one cycle after the accept.
- Throughput: one result per cycle while `in_valid` is held high. N vectors take N cycles of RUN.
- `sig_valid` stays high until `sig_ready`. A `sig_ready` asserted in the same cycle `sig_valid` first rises completes the handshake in that cycle.
- A `start` in the cycle DONE→IDLE is not seen; it must be presented while in IDLE.

## Structure
- Shared package `expr_regr_pkg`:
  - `RESULT_W`=90
  - default `TAPS` and `SEED`
  - state enum {IDLE, RUN, DONE}
  - typedef `result_t`, reused by the upstream operand generator and the expression wrapper.
- One natural sub-module, `misr_step`: a combinational next-signature function of (sig, data, TAPS). It is reused by the bench's reference model. The FSM and counter stay in the top.

## Test plan
- SEED=0, `start` with `num_vectors`=1, `in_data`=1 → one cycle after the accept, `sig_valid`=1, `signature`=1, `vec_count`=1.
- `num_vectors`=2, data 1 then 0 back-to-back → `signature`=2, `sig_valid` one cycle after the second accept.
- `num_vectors`=2, data 1<<89 then 0 → `signature`=TAPS (feedback path exercised).
- `num_vectors`=4 with `in_valid` toggling 1,0,1,0,… and `sig_ready` held low for 5 cycles in DONE → exactly 4 accepts, `signature` and `vec_count`=4 stable until `sig_ready`, then IDLE.
- `start` with `num_vectors`=0 → DONE next cycle with `signature`=SEED and `vec_count`=0. A second `start` during DONE is ignored.
- `reset` asserted after 3 of 8 accepts → next cycle IDLE, `in_ready`=0, `signature`=SEED, `vec_count`=0. A fresh 8-vector run then matches the model's signature.
